// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the processor
// and one secondary requester; the processor wins, with bounded starvation.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_active,
    input  logic        proc_wren,
    input  logic [11:0] proc_addr,
    input  logic [31:0] proc_data,
    output logic [31:0] proc_q,
    output logic        proc_stall,
    input  logic        periph_req,
    input  logic        periph_we,
    input  logic [11:0] periph_addr,
    input  logic [31:0] periph_wdata,
    output logic        periph_busy,
    output logic        periph_ack,
    output logic [31:0] periph_rdata,
    output logic        ram_wEn,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_dataIn,
    input  logic [31:0] ram_dataOut
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             lat_we;
    logic [11:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic             at_limit;
    logic             grant;

    assign at_limit = (wait_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        proc_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (periph_req) state_next = PEND;
            end
            PEND: begin
                grant      = !proc_active || at_limit;
                proc_stall = proc_active && at_limit;
                if (grant) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset keeps the RAM on the processor so a granted write is dropped.
        if (reset) begin
            grant      = 1'b0;
            proc_stall = 1'b0;
        end
    end

    assign ram_wEn    = grant ? lat_we    : proc_wren;
    assign ram_addr   = grant ? lat_addr  : proc_addr;
    assign ram_dataIn = grant ? lat_wdata : proc_data;
    assign proc_q     = ram_dataOut;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            periph_busy  <= 1'b0;
            periph_ack   <= 1'b0;
            periph_rdata <= '0;
        end else begin
            state      <= state_next;
            periph_ack <= (state == RESP);
            if (state == IDLE && periph_req) begin
                lat_we      <= periph_we;
                lat_addr    <= periph_addr;
                lat_wdata   <= periph_wdata;
                wait_cnt    <= '0;
                periph_busy <= 1'b1;
            end
            if (state == PEND && !grant && !at_limit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // Read data comes back one edge after the granted access.
            if (state == RESP) begin
                periph_rdata <= ram_dataOut;
                periph_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a
// request-timeline reference model and a shadow memory.
module tb_dmem_arbiter;

    localparam int LIMIT = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_active;
    logic        proc_wren;
    logic [11:0] proc_addr;
    logic [31:0] proc_data;
    logic [31:0] proc_q;
    logic        proc_stall;
    logic        periph_req;
    logic        periph_we;
    logic [11:0] periph_addr;
    logic [31:0] periph_wdata;
    logic        periph_busy;
    logic        periph_ack;
    logic [31:0] periph_rdata;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;

    logic [31:0] ram [4096];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram[ram_addr];
    end

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .proc_active(proc_active), .proc_wren(proc_wren),
        .proc_addr(proc_addr), .proc_data(proc_data),
        .proc_q(proc_q), .proc_stall(proc_stall),
        .periph_req(periph_req), .periph_we(periph_we),
        .periph_addr(periph_addr), .periph_wdata(periph_wdata),
        .periph_busy(periph_busy), .periph_ack(periph_ack),
        .periph_rdata(periph_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    logic [31:0] mem [4096];
    bit          known [4096];

    bit          m_busy = 0;
    bit          m_grd = 0;
    int          m_acc = 0;
    int          m_ackc = -10;
    bit          m_we = 0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_gv = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_q = '0;
    bit          m_qv = 0;

    int t_acc = 0;
    int t_stall = 0;
    int last_lat = 0;
    int last_ackc = 0;
    int ack_gap = 0;
    int n_stall = 0;
    int n_ack = 0;
    bit saw_ack = 0;
    bit prev_busy = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic set_proc(input logic a, input logic w,
                            input logic [11:0] ad, input logic [31:0] d);
        proc_active = a;
        proc_wren   = w;
        proc_addr   = ad;
        proc_data   = d;
    endtask

    task automatic set_per(input logic r, input logic w,
                           input logic [11:0] ad, input logic [31:0] d);
        periph_req   = r;
        periph_we    = w;
        periph_addr  = ad;
        periph_wdata = d;
    endtask

    // One clock: check this cycle's outputs, then advance the model.
    task automatic step();
        int          w;
        bit          g;
        bit          st;
        bit          b0;
        logic        e_we;
        logic [11:0] e_addr;
        logic [31:0] e_din;
        logic [31:0] old;
        #1;
        w = cyc - m_acc;
        if (w > LIMIT) w = LIMIT;
        g  = !reset && m_busy && !m_grd && (!proc_active || w >= LIMIT);
        st = !reset && m_busy && !m_grd && proc_active && w >= LIMIT;
        e_we   = g ? m_we    : proc_wren;
        e_addr = g ? m_addr  : proc_addr;
        e_din  = g ? m_wdata : proc_data;
        check("stall", 32'(proc_stall), 32'(st));
        check("ram_wEn", 32'(ram_wEn), 32'(e_we));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_dataIn", ram_dataIn, e_din);
        check("busy", 32'(periph_busy), 32'(m_busy));
        check("ack", 32'(periph_ack), 32'(cyc == m_ackc));
        check("rdata", periph_rdata, m_rdata);
        if (m_qv) check("proc_q", proc_q, m_q);
        saw_ack = periph_ack;
        if (proc_stall) begin
            n_stall++;
            t_stall = cyc;
        end
        if (periph_busy && !prev_busy) t_acc = cyc;
        prev_busy = periph_busy;
        if (periph_ack) begin
            last_lat  = cyc - t_acc;
            ack_gap   = cyc - last_ackc;
            last_ackc = cyc;
            n_ack++;
        end
        @(posedge clock);
        old  = mem[e_addr];
        m_qv = known[e_addr];
        m_q  = old;
        if (e_we) begin
            mem[e_addr]   = e_din;
            known[e_addr] = 1;
        end
        b0 = m_busy;
        if (reset) begin
            m_busy  = 0;
            m_grd   = 0;
            m_rdata = '0;
            m_ackc  = -10;
        end else begin
            if (m_busy && m_grd) begin
                m_rdata = m_gv;
                m_busy  = 0;
                m_grd   = 0;
                m_ackc  = cyc + 1;
            end else if (g) begin
                m_grd = 1;
                m_gv  = old;
            end
            if (!b0 && periph_req) begin
                m_busy  = 1;
                m_grd   = 0;
                m_acc   = cyc + 1;
                m_we    = periph_we;
                m_addr  = periph_addr;
                m_wdata = periph_wdata;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic wait_ack(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = saw_ack;
        end
        check("ack_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        logic [11:0] b2b_a [3];
        logic [31:0] b2b_v [3];
        int          p_act;
        int          acks0;
        b2b_a[0] = 12'h010;
        b2b_a[1] = 12'h020;
        b2b_a[2] = 12'h030;
        b2b_v[0] = 32'hDEADBEEF;
        b2b_v[1] = 32'h12345678;
        b2b_v[2] = 32'hC0FFEE03;

        reset = 1'b1;
        set_proc(0, 0, 12'h000, 32'h0);
        set_per(0, 0, 12'h000, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        step();
        reset = 1'b0;

        for (int a = 0; a < 16; a++) begin
            set_proc(1, 1, 12'(a), $urandom);
            step();
        end
        set_proc(1, 1, 12'h020, 32'h12345678); step();
        set_proc(1, 1, 12'h040, 32'hA5A50040); step();
        set_proc(1, 1, 12'h010, 32'h0); step();
        set_proc(1, 1, 12'h030, 32'h0); step();

        // Idle processor: write then read back.
        set_proc(0, 0, 12'h000, 32'h0);
        n_stall = 0;
        set_per(1, 1, 12'h010, 32'hDEADBEEF); step();
        set_per(0, 0, 12'h000, 32'h0);
        wait_ack(10);
        check("idle_wr_lat", 32'(last_lat), 32'd2);
        set_per(1, 0, 12'h010, 32'h0); step();
        set_per(0, 0, 12'h000, 32'h0);
        wait_ack(10);
        check("idle_rd_lat", 32'(last_lat), 32'd2);
        check("idle_rd_data", periph_rdata, 32'hDEADBEEF);
        check("idle_stalls", 32'(n_stall), 32'd0);

        // Busy processor: starvation forces exactly one stall.
        set_proc(1, 0, 12'h005, 32'h0);
        n_stall = 0;
        set_per(1, 0, 12'h020, 32'h0); step();
        set_per(0, 0, 12'h000, 32'h0);
        wait_ack(30);
        check("starve_stalls", 32'(n_stall), 32'd1);
        check("starve_stall_at", 32'(t_stall - t_acc), 32'(LIMIT));
        check("starve_lat", 32'(last_lat), 32'(LIMIT + 2));
        check("starve_data", periph_rdata, 32'h12345678);

        // Processor gap of three cycles, processor writing 0x030.
        n_stall = 0;
        set_proc(1, 1, 12'h030, 32'hC0FFEE03);
        set_per(1, 0, 12'h010, 32'h0); step();
        set_per(0, 0, 12'h000, 32'h0);
        repeat (3) step();
        set_proc(0, 0, 12'h000, 32'h0);
        wait_ack(20);
        check("gap_lat", 32'(last_lat), 32'd5);
        check("gap_stalls", 32'(n_stall), 32'd0);
        check("gap_data", periph_rdata, 32'hDEADBEEF);
        check("gap_ram030", ram[12'h030], 32'hC0FFEE03);

        // Processor passthrough store then load.
        set_proc(1, 1, 12'h005, 32'd42); step();
        set_proc(1, 0, 12'h005, 32'h0); step();
        check("pt_q", proc_q, 32'd42);

        // Reset while a write is being granted.
        set_proc(0, 0, 12'h000, 32'h0);
        set_per(1, 1, 12'h040, 32'h77); step();
        set_per(0, 0, 12'h000, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy", 32'(periph_busy), 32'd0);
        acks0 = n_ack;
        repeat (4) step();
        check("rst_no_ack", 32'(n_ack - acks0), 32'd0);
        check("rst_ram040", ram[12'h040], 32'hA5A50040);

        // Back-to-back reads with req held high.
        for (int k = 0; k < 10; k++) begin
            set_per(k < 9, 0, b2b_a[(k / 3 > 2) ? 2 : k / 3], 32'h0);
            step();
            if (k % 3 == 0 && k > 0) begin
                check("b2b_ack", 32'(saw_ack), 32'd1);
                check("b2b_rd", periph_rdata, b2b_v[k / 3 - 1]);
                if (k > 3) check("b2b_gap", 32'(ack_gap), 32'd3);
            end
        end

        // Random traffic in phases of differing processor load.
        for (int ph = 0; ph < 12; ph++) begin
            case (ph % 4)
                0: p_act = 0;
                1: p_act = 50;
                2: p_act = 90;
                default: p_act = 100;
            endcase
            for (int c = 0; c < 50; c++) begin
                set_proc($urandom_range(99) < p_act, $urandom_range(1),
                         12'($urandom_range(15)), $urandom);
                if (!proc_active) proc_wren = 1'b0;
                set_per($urandom_range(99) < 30, $urandom_range(1),
                        12'($urandom_range(15)), $urandom);
                reset = ($urandom_range(99) == 0);
                step();
            end
        end
        reset = 1'b0;
        set_per(0, 0, 12'h000, 32'h0);
        set_proc(0, 0, 12'h000, 32'h0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
